// File: rtl/pcn_pkg.sv
// Shared definitions for the stochastic check-node tracker: FSM encoding and
// the counter width helper.
package pcn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_DONE_OK = 2'd2,
    ST_DONE_TO = 2'd3
  } state_t;

  // Bits needed to hold values 0..max inclusive.
  function automatic int cnt_width(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction

endpackage

// File: rtl/pcn_parity.sv
// DEG-input XOR reduction producing the check-node parity bit.
module pcn_parity #(
  parameter int DEG = 6
) (
  input  logic [DEG-1:0] q,
  output logic           p
);

  assign p = ^q;

endmodule

// File: rtl/pcn_track.sv
// Stochastic LDPC check node: forms extrinsic edge bits each decode cycle and
// tracks per-frame convergence (SAT_WIN satisfied in a row) or cycle timeout.
module pcn_track
  import pcn_pkg::*;
#(
  parameter int  DEG     = 6,
  parameter int  SAT_WIN = 16,
  parameter int  MAX_CYC = 1024,
  localparam int CW      = cnt_width(MAX_CYC)
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic           start,
  input  logic           en,
  input  logic [DEG-1:0] Q,
  output logic [DEG-1:0] R,
  output logic           pc_sat,
  output logic           converged,
  output logic           timeout,
  output logic           busy,
  output logic [CW-1:0]  cyc_cnt
);

  localparam int            SW      = cnt_width(SAT_WIN);
  localparam logic [SW-1:0] SAT_LIM = SW'(SAT_WIN);
  localparam logic [CW-1:0] CYC_LIM = CW'(MAX_CYC);

  state_t         state, state_n;
  logic [SW-1:0]  sat_cnt, sat_cnt_n;
  logic [CW-1:0]  cyc_cnt_n;
  logic [DEG-1:0] r_n;
  logic           pc_sat_n, conv_n, tmo_n;
  logic           p;
  logic [SW-1:0]  sat_inc;
  logic [CW-1:0]  cyc_inc;

  pcn_parity #(.DEG(DEG)) u_parity (.q(Q), .p(p));

  assign sat_inc = sat_cnt + 1'b1;
  assign cyc_inc = cyc_cnt + 1'b1;
  assign busy    = (state == ST_RUN);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      R         <= '0;
      pc_sat    <= 1'b0;
      cyc_cnt   <= '0;
      sat_cnt   <= '0;
      converged <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      R         <= r_n;
      pc_sat    <= pc_sat_n;
      cyc_cnt   <= cyc_cnt_n;
      sat_cnt   <= sat_cnt_n;
      converged <= conv_n;
      timeout   <= tmo_n;
    end
  end

  always_comb begin
    state_n   = state;
    r_n       = R;
    pc_sat_n  = pc_sat;
    cyc_cnt_n = cyc_cnt;
    sat_cnt_n = sat_cnt;
    conv_n    = converged;
    tmo_n     = timeout;

    if (start) begin
      // A new frame restarts from any state; this cycle's Q/en belong to no frame.
      state_n   = ST_RUN;
      r_n       = '0;
      pc_sat_n  = 1'b0;
      cyc_cnt_n = '0;
      sat_cnt_n = '0;
      conv_n    = 1'b0;
      tmo_n     = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          r_n       = '0;
          pc_sat_n  = 1'b0;
          cyc_cnt_n = '0;
          sat_cnt_n = '0;
        end
        ST_RUN: begin
          if (en) begin
            r_n       = Q ^ {DEG{p}};
            pc_sat_n  = ~p;
            cyc_cnt_n = cyc_inc;
            sat_cnt_n = p ? '0 : sat_inc;
            // Convergence takes priority when it lands on the last budgeted cycle.
            if (!p && sat_inc == SAT_LIM) begin
              state_n = ST_DONE_OK;
              conv_n  = 1'b1;
            end else if (cyc_inc == CYC_LIM) begin
              state_n = ST_DONE_TO;
              tmo_n   = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pcn_track.md
PCN_TRACK -- requirements
Module: pcn_track

Interface
REQ-001 Parameter DEG, default 6: check-node degree, number of edges; SHALL be >= 2.
REQ-002 Parameter SAT_WIN, default 16: consecutive satisfied cycles required to declare convergence; SHALL be >= 1.
REQ-003 Parameter MAX_CYC, default 1024: decode-cycle budget per frame; SHALL be >= SAT_WIN.
REQ-004 Derived constant CW = clog2(MAX_CYC+1): counter width.
REQ-005 CLK  input  1  single clock; all state updates on rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  frame-start pulse; sampled each cycle.
REQ-008 en  input  1  Q valid this cycle (one stochastic decode cycle).
REQ-009 Q  input  DEG  incoming stochastic edge bits from variable nodes.
REQ-010 R  output  DEG  registered extrinsic edge bits to variable nodes.
REQ-011 pc_sat  output  1  registered; 1 = parity of last accepted Q was even (check satisfied).
REQ-012 converged  output  1  sticky; SAT_WIN consecutive satisfied cycles reached.
REQ-013 timeout  output  1  sticky; MAX_CYC accepted cycles elapsed without convergence.
REQ-014 busy  output  1  1 while in RUN.
REQ-015 cyc_cnt  output  CW  accepted-cycle count for the current frame.

Function
REQ-016 Parity p = XOR of all DEG bits of Q, combinational, for any DEG >= 2.
REQ-017 States: IDLE, RUN, DONE_OK, DONE_TO; busy = (state == RUN).
REQ-018 IDLE: R, pc_sat, cyc_cnt, internal sat_cnt held at 0; start -> RUN.
REQ-019 RUN, en=1: R <= Q XOR {DEG{p}}; pc_sat <= ~p; cyc_cnt <= cyc_cnt+1; sat_cnt <= p ? 0 : sat_cnt+1.
REQ-020 Latency Q -> R, pc_sat: exactly 1 cycle.
REQ-021 RUN, en=0: R, pc_sat, cyc_cnt, sat_cnt, state all held.
REQ-022 RUN, en=1, p=0, sat_cnt+1 == SAT_WIN -> DONE_OK, converged <= 1 in the same edge.
REQ-023 RUN, en=1, cyc_cnt+1 == MAX_CYC, convergence not met -> DONE_TO, timeout <= 1.
REQ-024 Both conditions in the same cycle -> DONE_OK wins; timeout stays 0.
REQ-025 DONE_OK / DONE_TO: R, pc_sat, cyc_cnt, flags held; en ignored.
REQ-026 start in any state -> RUN; R, pc_sat, cyc_cnt, sat_cnt, converged, timeout cleared on that edge; Q/en on the start cycle ignored.
REQ-027 Counters SHALL never wrap: sat_cnt max SAT_WIN, cyc_cnt max MAX_CYC.

Reset
REQ-028 RST=1 SHALL immediately force IDLE with R=0, pc_sat=0, converged=0, timeout=0, cyc_cnt=0, busy=0, sat_cnt=0, independent of CLK.
REQ-029 Reset mid-RUN SHALL discard the frame; after deassertion the block waits for start.

Structure
REQ-030 Shared package pcn_pkg holds the state encoding constants and the CW width function.
REQ-031 One sub-module pcn_parity (parametrised DEG-input XOR reduction, output p) is instantiated once; all sequential logic lives in pcn_track.

Verification (DEG=6, SAT_WIN=4, MAX_CYC=10)
REQ-032 start, then en with Q=000011 -> next cycle R=000011, pc_sat=1; then Q=000111 -> R=111000, pc_sat=0.
REQ-033 start, four consecutive en cycles with even-parity Q -> converged=1 after the 4th edge, busy=0, cyc_cnt=4.
REQ-034 start, 3 satisfied, 1 unsatisfied, 4 satisfied -> converged after the 8th en cycle, cyc_cnt=8.
REQ-035 start, 10 en cycles all odd parity -> timeout=1, converged=0, cyc_cnt=10; further en has no effect.
REQ-036 en gaps of 3 idle cycles inside RUN -> R, cyc_cnt, sat_cnt unchanged during gaps; a 4th satisfied cycle after a gap still converges.
REQ-037 RST pulsed asynchronously mid-RUN with cyc_cnt=5 -> all outputs 0 before the next CLK edge; start during DONE_TO -> flags cleared, busy=1 next cycle.
